// File: rtl/instruction_fetch_pkg.sv
// Shared constants, FSM encoding and opcode helper for the instruction fetch
// sequencer and its bench.
package instruction_fetch_pkg;

    localparam int PC_W        = 8;
    localparam int DATA_W      = 16;
    localparam int MEM_DEPTH   = 1 << PC_W;
    localparam int ACK_TIMEOUT = 4;
    localparam int CNT_W       = 3;

    localparam logic [2:0] HALT_OPCODE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LOAD      = 3'd2,
        S_START     = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    function automatic logic is_halt(input logic [DATA_W-1:0] word);
        return word[15:13] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instruction_fetch_mem.sv
// 256x16 program store: synchronous write port, synchronous registered read port.
module instr_mem
    import instruction_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [PC_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [PC_W-1:0]   i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array has no reset on purpose; program contents must survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The read register doubles as the instruction register, so it alone is cleared.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch/start sequencer: fetches words from instr_mem, hands them to the core
// with load/s strobes and waits for the core's busy/done handshake on w.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              w,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] instr,
    output logic              load,
    output logic              s,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              err
);

    state_t            r_state;
    state_t            w_next;
    logic [PC_W-1:0]   r_pc;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_rdata;
    logic              w_mem_we;
    logic              w_timeout;

    assign w_mem_we  = !reset && (r_state == S_IDLE) && prog_we;
    assign w_timeout = (r_state == S_WAIT_BUSY) && w && (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

    instr_mem u_mem (
        .clk     (clk),
        .i_reset (reset),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_re    (r_state == S_FETCH),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (run && !prog_we) w_next = S_FETCH;
            S_FETCH:     w_next = S_LOAD;
            S_LOAD:      w_next = is_halt(w_rdata) ? S_HALT : S_START;
            S_START:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!w)             w_next = S_WAIT_DONE;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_WAIT_DONE: if (w) w_next = run ? S_FETCH : S_IDLE;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_FETCH) begin
                r_err <= 1'b0;
            end
            if (r_state == S_LOAD && !is_halt(w_rdata)) begin
                r_pc <= r_pc + 1'b1;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY && w) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_timeout) r_err <= 1'b1;
            end
        end
    end

    assign instr  = w_rdata;
    assign load   = (r_state == S_LOAD) && !is_halt(w_rdata);
    assign s      = (r_state == S_START);
    assign halted = (r_state == S_HALT);
    assign pc     = r_pc;
    assign err    = r_err;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: expected {instr, pc} pairs are queued
// when a run is launched and popped by a monitor on every load strobe.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset, run, w, prog_we;
    logic [PC_W-1:0]   prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] instr;
    logic              load, s, halted, err;
    logic [PC_W-1:0]   pc;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0, n_err = 0;
    int   load_cnt = 0, s_cnt = 0;
    int   l0, s0;
    bit   core_dead = 1'b0;

    instruction_fetch dut (
        .clk(clk), .reset(reset), .run(run), .w(w),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instr(instr), .load(load), .s(s), .pc(pc), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input state_t st, input int max_cyc, input string tag);
        int n = 0;
        while (dut.r_state !== st && n < max_cyc) begin
            step(1);
            n++;
        end
        check(tag, 32'(dut.r_state == st), 32'd1);
    endtask

    task automatic prog_write(input logic [PC_W-1:0] a, input logic [DATA_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step(1);
        prog_we   = 1'b0;
    endtask

    task automatic launch(input logic [PC_W-1:0] a, input logic [DATA_W-1:0] d);
        sb.push_back('{instr: d, pc: a});
        run = 1'b1;
        step(1);
        run = 1'b0;
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (s === 1'b1) s_cnt++;
        if (load === 1'b1) begin
            load_cnt++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("load_instr", 32'(instr), 32'(mon_e.instr));
                check("load_pc", 32'(pc), 32'(mon_e.pc));
            end
        end
    end

    // Core model: drops w the cycle after s, raises it two cycles later.
    initial begin
        w = 1'b1;
        forever begin
            step(1);
            if (s === 1'b1 && !core_dead) begin
                step(1);
                w = 1'b0;
                step(2);
                w = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        step(2);
        reset = 1'b0;
        check("rst_state",  32'(dut.r_state), 32'(S_IDLE));
        check("rst_pc",     32'(pc), 32'd0);
        check("rst_instr",  32'(instr), 32'd0);
        check("rst_strobe", {30'd0, load, s}, 32'd0);
        check("rst_flags",  {30'd0, halted, err}, 32'd0);

        // Write and run in the same IDLE cycle: write wins, no fetch.
        run = 1'b1; prog_we = 1'b1; prog_addr = 8'h00; prog_data = 16'hD105;
        step(1);
        check("collide_state", 32'(dut.r_state), 32'(S_IDLE));
        run = 1'b0; prog_we = 1'b0;
        step(1);
        check("collide_idle", 32'(dut.r_state), 32'(S_IDLE));
        prog_write(8'h01, 16'hE000);

        // One instruction then HALT; prog_we while busy must be ignored.
        sb.push_back('{instr: 16'hD105, pc: 8'h00});
        l0 = load_cnt; s0 = s_cnt;
        run = 1'b1;
        step(1);
        check("run_fetch", 32'(dut.r_state), 32'(S_FETCH));
        prog_we = 1'b1; prog_addr = 8'h00; prog_data = 16'hFFFF;
        wait_state(S_HALT, 40, "halt_reached");
        check("halt_flag",   32'(halted), 32'd1);
        check("halt_strobe", {30'd0, load, s}, 32'd0);
        check("halt_pc",     32'(pc), 32'd1);  // HALT leaves pc at the halting word
        check("halt_instr",  32'(instr), 32'hE000);
        check("halt_loads",  32'(load_cnt - l0), 32'd1);
        check("halt_starts", 32'(s_cnt - s0), 32'd1);
        step(3);
        check("halt_absorb", 32'(dut.r_state), 32'(S_HALT));
        prog_we = 1'b0; run = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("halt_rst", {23'd0, halted, pc}, 32'd0);

        // Single step with nominal latency; also reads back mem[0].
        sb.push_back('{instr: 16'hD105, pc: 8'h00});
        run = 1'b1;
        step(1);
        run = 1'b0;
        check("lat_fetch", 32'(dut.r_state), 32'(S_FETCH));
        step(1);
        check("lat_load", 32'(load), 32'd1);
        step(1);
        check("lat_s", {30'd0, load, s}, 32'd1);
        wait_state(S_IDLE, 20, "step_idle");
        check("step_pc", 32'(pc), 32'd1);
        step(3);
        check("step_stays_idle", 32'(dut.r_state), 32'(S_IDLE));

        // Core never acknowledges: err after four WAIT_BUSY cycles.
        prog_write(8'h01, 16'h1234);
        core_dead = 1'b1;
        launch(8'h01, 16'h1234);
        step(2);
        check("to_start", 32'(s), 32'd1);
        step(1);
        check("to_busy", 32'(dut.r_state), 32'(S_WAIT_BUSY));
        step(3);
        check("to_busy_4", {30'd0, dut.r_state == S_WAIT_BUSY, err}, 32'd2);
        step(1);
        check("to_idle", 32'(dut.r_state), 32'(S_IDLE));
        check("to_err", 32'(err), 32'd1);
        core_dead = 1'b0;
        step(2);
        prog_write(8'h02, 16'h2345);
        check("err_sticky", 32'(err), 32'd1);
        launch(8'h02, 16'h2345);
        check("err_cleared", {30'd0, dut.r_state == S_FETCH, err}, 32'd2);
        wait_state(S_IDLE, 20, "err_run_idle");
        check("err_run_pc", 32'(pc), 32'd3);

        // Reset while waiting for the core to finish.
        prog_write(8'h03, 16'h3456);
        launch(8'h03, 16'h3456);
        wait_state(S_WAIT_DONE, 20, "reach_wait_done");
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("wd_rst_state", 32'(dut.r_state), 32'(S_IDLE));
        check("wd_rst_regs",  {15'd0, err, pc, 8'd0}, 32'd0);
        check("wd_rst_instr", 32'(instr), 32'd0);
        l0 = load_cnt; s0 = s_cnt;
        step(5);
        check("wd_no_strobes", 32'((load_cnt - l0) + (s_cnt - s0)), 32'd0);
        launch(8'h00, 16'hD105);
        wait_state(S_IDLE, 20, "readback_idle");
        check("readback_pc", 32'(pc), 32'd1);

        // PC wrap: 256 non-HALT words, run dropped during the last LOAD.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            prog_write(8'(i), {8'h40, 8'(i)});
            sb.push_back('{instr: {8'h40, 8'(i)}, pc: 8'(i)});
        end
        l0 = load_cnt;
        run = 1'b1;
        begin
            int n = 0;
            while (!(dut.r_state == S_LOAD && pc == 8'hFF) && n < 3000) begin
                step(1);
                n++;
            end
            check("wrap_reach_ff", 32'(n < 3000), 32'd1);
        end
        run = 1'b0;
        wait_state(S_IDLE, 20, "wrap_idle");
        check("wrap_pc", 32'(pc), 32'd0);
        check("wrap_loads", 32'(load_cnt - l0), 32'd256);

        step(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
